// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, default depth and the {pc, instr} FIFO entry type
package fetch_pkg;
  localparam int FETCH_PC_W    = 8;
  localparam int FETCH_INSTR_W = 8;
  localparam int FETCH_DEPTH   = 4;
  typedef struct packed {
    logic [FETCH_PC_W-1:0]    pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with flush
// Ports: clk, rst_n (sync active-low), push/din, pop, flush (empties the FIFO,
// overrides push/pop), head (entry at read pointer), count (occupancy 0..DEPTH).
module fetch_fifo import fetch_pkg::*; #(
  parameter int  DEPTH = FETCH_DEPTH,
  parameter type T     = fetch_entry_t
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  input  logic                     flush,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  T                mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  always_comb begin
    wr_ptr_d = flush ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = flush ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push && !flush) mem_q[wr_ptr_q] <= din;
    end
  end
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage with PC, credit-limited issue, response FIFO and redirect
// Ports: clk, rst_n (sync active-low); imem_addr/imem_en/imem_rdata (1-cycle-latency
// instruction memory); redirect_valid/redirect_pc (flush and restart); out_valid/out_ready/
// out_pc/out_instr (decode handshake). Optional FETCH_PERF_CNT_EN adds perf_stall_cnt,
// a saturating count of cycles with out_valid && !out_ready.
module fetch_queue import fetch_pkg::*; #(
  parameter int              PC_W     = FETCH_PC_W,
  parameter int              INSTR_W  = FETCH_INSTR_W,
  parameter int              DEPTH    = FETCH_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = '0
)(
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
`ifdef FETCH_PERF_CNT_EN
  ,output logic [31:0]       perf_stall_cnt
`endif
);
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;
  logic [PC_W-1:0]        pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   push, pop;
  logic [$clog2(DEPTH):0] count;
  entry_t                 push_data, head;
  // Credit counts the in-flight read so a push can never hit a full FIFO.
  assign imem_en   = rst_n && !redirect_valid && (int'(count) + int'(rsp_valid_q) < DEPTH);
  assign imem_addr = pc_q;
  assign push      = rsp_valid_q && !redirect_valid;
  assign out_valid = (count != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign push_data = '{pc: rsp_pc_q, instr: imem_rdata};
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  always_comb begin
    pc_d        = redirect_valid ? redirect_pc : imem_en ? pc_q + PC_W'(1) : pc_q;
    rsp_valid_d = imem_en;
    rsp_pc_d    = imem_en ? pc_q : rsp_pc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      rsp_valid_q <= 1'b0;
      rsp_pc_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_pc_q    <= rsp_pc_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .flush (redirect_valid),
    .head  (head),
    .count (count)
  );
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  always_comb perf_stall_cnt_d = (out_valid && !out_ready && perf_stall_cnt_q != '1) ? perf_stall_cnt_q + 32'd1 : perf_stall_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) perf_stall_cnt_q <= '0;
    else        perf_stall_cnt_q <= perf_stall_cnt_d;
  end
  assign perf_stall_cnt = perf_stall_cnt_q;
`endif
endmodule
